i2c_bus_monitor: RTL and testbench
==================================

// Module: i2c_bus_monitor
// PURPOSE
//   Front-end conditioning stage directly upstream of the i2c_wrapper slave/master controllers.
//   Synchronises raw SDA/SCL pad inputs, removes glitches, and emits single-cycle event strobes
//   (SCL edges, START, repeated START, STOP, bus error, SCL-low timeout) plus a bus_busy level.
//   The controllers sample bits and sequence their FSMs from these strobes, never from raw pins.
// PARAMETERS
//   FILTER_DEPTH   4        consecutive stable cycles required before a filtered line changes (>=1)
//   TIMEOUT_CYCLES 50000    SCL-low cycles while busy before bus_timeout fires (0 disables)
// PORTS
//   clk          in   1   system clock
//   n_rst        in   1   asynchronous active-low reset
//   SDA_in       in   1   raw SDA pad input (asynchronous)
//   SCL_in       in   1   raw SCL pad input (asynchronous)
//   SDA_filt     out  1   synchronised, filtered SDA
//   SCL_filt     out  1   synchronised, filtered SCL
//   SCL_rise     out  1   1-cycle pulse: SCL_filt 0->1 (data sample point)
//   SCL_fall     out  1   1-cycle pulse: SCL_filt 1->0 (data drive point)
//   start_det    out  1   1-cycle pulse: START from idle
//   rstart_det   out  1   1-cycle pulse: START while bus_busy (repeated START)
//   stop_det     out  1   1-cycle pulse: STOP
//   bus_error    out  1   1-cycle pulse: SDA_filt and SCL_filt changed in same cycle
//   bus_timeout  out  1   1-cycle pulse: SCL low > TIMEOUT_CYCLES while busy
//   bus_busy     out  1   level: high from START until STOP/timeout
// BEHAVIOUR
//   - Reset: sync flops, SDA_filt, SCL_filt = 1 (idle-high bus); all pulses, bus_busy = 0;
//     filter and timeout counters = 0. Reset mid-transfer returns to idle with no pulse on release.
//   - Sync: 2-FF chain per line; no logic between stages.
//   - Filter (per line): counter increments while synced value != filtered value, clears when equal.
//     Counter reaching FILTER_DEPTH-1 with mismatch: filtered value toggles next edge, counter clears.
//     Glitch shorter than FILTER_DEPTH cycles never propagates.
//     Pin-to-filtered latency = 2 + FILTER_DEPTH cycles.
//   - Edges and conditions: all strobes registered, asserted exactly the cycle after filtered value change.
//     SCL_rise/SCL_fall from SCL_filt vs previous value.
//     START: SDA_filt 1->0 with SCL_filt high and unchanged. Goes to start_det if !bus_busy, else rstart_det.
//     STOP: SDA_filt 0->1 with SCL_filt high and unchanged.
//     Simultaneous SDA and SCL change: bus_error only. No START/STOP. SCL_rise/SCL_fall still pulse.
//   - bus_busy FSM: IDLE, BUSY.
//     IDLE->BUSY on START; BUSY->IDLE on STOP or bus_timeout.
//     rstart keeps BUSY. STOP in IDLE pulses stop_det, stays IDLE.
//     bus_busy updates the same cycle the strobe asserts.
//   - Timeout: counter runs only in BUSY with SCL_filt=0, clears on SCL_filt=1 or IDLE.
//     Counter saturates; bus_timeout pulses once, when counter reaches TIMEOUT_CYCLES.
//     TIMEOUT_CYCLES=0 disables the counter; bus_timeout tied 0.
//   - Counter widths: $clog2(param+1). Counters never wrap.
// STRUCTURE
//   - i2c_pkg: bus_state_t enum {IDLE, BUSY}; I2C_IDLE_LEVEL = 1'b1 constant.
//   - Sub-module i2c_glitch_filter (sync + stability counter, param FILTER_DEPTH).
//     Instantiated once for SDA and once for SCL.
//   - Top holds edge detect, condition decode, busy FSM, timeout counter.
// TESTING
//   - Reset release, both pins held 1 for 20 cycles -> all pulses 0, bus_busy 0, SDA_filt/SCL_filt 1.
//   - SCL=1, SDA 1->0 -> start_det exactly 7 cycles later (FILTER_DEPTH=4), bus_busy 1 same cycle;
//     SDA 0->1 -> stop_det, bus_busy 0.
//   - SDA low pulse of 3 cycles with SCL=1 -> no SDA_filt change, no start_det;
//     4-cycle pulse -> start_det then stop_det.
//   - START, 8 SCL clocks at 50-cycle half period -> 8 SCL_rise and 8 SCL_fall;
//     second START before STOP -> rstart_det, not start_det.
//   - SDA and SCL toggled the same clk edge -> bus_error pulse, no start_det/stop_det.
//   - TIMEOUT_CYCLES=100, START then SCL held low -> one bus_timeout ~100 cycles after SCL_fall;
//     bus_busy 0; n_rst asserted mid-transfer -> idle outputs immediately.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus front end.
// The idle level of both bus lines is high.
package i2c_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_t;

  localparam logic I2C_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a stability counter for one open-drain line.
// The filtered output follows the pad only after FILTER_DEPTH consecutive disagreeing samples.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_DEPTH = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic line_in,
  output logic line_filt
);

  localparam int CW = $clog2(FILTER_DEPTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(FILTER_DEPTH - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] stable_cnt;

  // The count measures how long the synchronised line has disagreed with the filtered one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_1     <= I2C_IDLE_LEVEL;
      sync_2     <= I2C_IDLE_LEVEL;
      line_filt  <= I2C_IDLE_LEVEL;
      stable_cnt <= '0;
    end else begin
      sync_1 <= line_in;
      sync_2 <= sync_1;
      if (sync_2 != line_filt) begin
        if (stable_cnt == LAST_COUNT) begin
          line_filt  <= sync_2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Conditions raw SDA/SCL pads and turns filtered line changes into single-cycle bus event
// strobes plus a bus_busy level for the downstream I2C controllers.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int FILTER_DEPTH   = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic SDA_in,
  input  logic SCL_in,
  output logic SDA_filt,
  output logic SCL_filt,
  output logic SCL_rise,
  output logic SCL_fall,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_error,
  output logic bus_timeout,
  output logic bus_busy
);

  bus_state_t state;
  logic       sda_prev;
  logic       scl_prev;
  logic       sda_chg;
  logic       scl_chg;
  logic       start_cond;
  logic       stop_cond;
  logic       error_cond;
  logic       timeout_hit;

  i2c_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filter (
    .clk       (clk),
    .n_rst     (n_rst),
    .line_in   (SDA_in),
    .line_filt (SDA_filt)
  );

  i2c_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filter (
    .clk       (clk),
    .n_rst     (n_rst),
    .line_in   (SCL_in),
    .line_filt (SCL_filt)
  );

  // A simultaneous change of both lines is ambiguous, so it is reported as an error only.
  always_comb begin
    sda_chg    = SDA_filt ^ sda_prev;
    scl_chg    = SCL_filt ^ scl_prev;
    start_cond = sda_chg && !SDA_filt && SCL_filt && !scl_chg;
    stop_cond  = sda_chg &&  SDA_filt && SCL_filt && !scl_chg;
    error_cond = sda_chg && scl_chg;
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
      localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT_CYCLES - 1);

      logic [TW-1:0] low_cnt;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          low_cnt <= '0;
        end else if (state == BUSY && !SCL_filt) begin
          if (low_cnt != T_MAX) begin
            low_cnt <= low_cnt + 1'b1;
          end
        end else begin
          low_cnt <= '0;
        end
      end

      assign timeout_hit = (state == BUSY) && !SCL_filt && (low_cnt == T_PRE);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Busy tracking and all strobes share one register stage so they line up exactly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      bus_busy    <= 1'b0;
      sda_prev    <= I2C_IDLE_LEVEL;
      scl_prev    <= I2C_IDLE_LEVEL;
      SCL_rise    <= 1'b0;
      SCL_fall    <= 1'b0;
      start_det   <= 1'b0;
      rstart_det  <= 1'b0;
      stop_det    <= 1'b0;
      bus_error   <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      sda_prev    <= SDA_filt;
      scl_prev    <= SCL_filt;
      SCL_rise    <= scl_chg &&  SCL_filt;
      SCL_fall    <= scl_chg && !SCL_filt;
      start_det   <= start_cond && (state == IDLE);
      rstart_det  <= start_cond && (state == BUSY);
      stop_det    <= stop_cond;
      bus_error   <= error_cond;
      bus_timeout <= timeout_hit;
      case (state)
        IDLE: begin
          if (start_cond) begin
            state    <= BUSY;
            bus_busy <= 1'b1;
          end
        end
        BUSY: begin
          if (stop_cond || timeout_hit) begin
            state    <= IDLE;
            bus_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          bus_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: directed bus scenarios plus random pad activity,
// every cycle compared against a behavioural model of the bus rules.
module tb_i2c_bus_monitor;
  localparam int FD = 4;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic n_rst;
  logic sda_pin;
  logic scl_pin;
  logic sda_filt, scl_filt, scl_rise, scl_fall, start_det, rstart_det;
  logic stop_det, bus_error, bus_timeout, bus_busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: recent pad samples and the resulting bus view.
  logic m_sda_hist[$];
  logic m_scl_hist[$];
  logic m_sda_f, m_scl_f, m_sda_last, m_scl_last, m_busy;
  logic m_rise, m_fall, m_start, m_rstart, m_stop, m_err, m_tmo;
  int   m_low_run;

  int n_rise, n_fall, n_start, n_rstart, n_stop, n_err, n_tmo;
  int cyc;
  int first_hit;
  int fall_cyc;
  logic sda_went_low;

  always #5 clk = ~clk;

  i2c_bus_monitor #(.FILTER_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .SDA_in      (sda_pin),
    .SCL_in      (scl_pin),
    .SDA_filt    (sda_filt),
    .SCL_filt    (scl_filt),
    .SCL_rise    (scl_rise),
    .SCL_fall    (scl_fall),
    .start_det   (start_det),
    .rstart_det  (rstart_det),
    .stop_det    (stop_det),
    .bus_error   (bus_error),
    .bus_timeout (bus_timeout),
    .bus_busy    (bus_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // A line changes once the pad value seen through two flops has disagreed for FD samples.
  function automatic logic window_disagrees(input logic hist[$], input logic f);
    for (int i = 0; i < FD; i++)
      if (hist[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    m_sda_hist = {};
    m_scl_hist = {};
    for (int i = 0; i < FD + 2; i++) begin
      m_sda_hist.push_back(1'b1);
      m_scl_hist.push_back(1'b1);
    end
    m_sda_f = 1'b1; m_scl_f = 1'b1; m_sda_last = 1'b1; m_scl_last = 1'b1;
    m_busy = 1'b0; m_low_run = 0;
    {m_rise, m_fall, m_start, m_rstart, m_stop, m_err, m_tmo} = '0;
  endtask

  task automatic modelStep(input logic sda, input logic scl);
    logic sda_chg, scl_chg, is_start, is_stop;
    sda_chg  = m_sda_f != m_sda_last;
    scl_chg  = m_scl_f != m_scl_last;
    m_rise   = scl_chg && m_scl_f;
    m_fall   = scl_chg && !m_scl_f;
    m_err    = sda_chg && scl_chg;
    is_start = sda_chg && !m_sda_f && m_scl_f && !scl_chg;
    is_stop  = sda_chg && m_sda_f && m_scl_f && !scl_chg;
    m_start  = is_start && !m_busy;
    m_rstart = is_start && m_busy;
    m_stop   = is_stop;
    if (m_busy && !m_scl_f) m_low_run++;
    else m_low_run = 0;
    m_tmo = (m_low_run == TO);
    if (is_start) m_busy = 1'b1;
    else if (is_stop || m_tmo) m_busy = 1'b0;
    m_sda_last = m_sda_f;
    m_scl_last = m_scl_f;
    m_sda_hist.push_back(sda); void'(m_sda_hist.pop_front());
    m_scl_hist.push_back(scl); void'(m_scl_hist.pop_front());
    if (window_disagrees(m_sda_hist, m_sda_f)) m_sda_f = ~m_sda_f;
    if (window_disagrees(m_scl_hist, m_scl_f)) m_scl_f = ~m_scl_f;
  endtask

  task automatic clearTally();
    {n_rise, n_fall, n_start, n_rstart, n_stop, n_err, n_tmo} = '0;
    cyc = 0;
    first_hit = -1;
    sda_went_low = 1'b0;
  endtask

  // Called at a falling clk edge; returns at the next falling edge with outputs checked.
  task automatic applyStimulus(input logic sda, input logic scl);
    sda_pin = sda;
    scl_pin = scl;
    @(posedge clk);
    modelStep(sda, scl);
    @(negedge clk);
    cyc++;
    checkOutput("SDA_filt", sda_filt, m_sda_f);
    checkOutput("SCL_filt", scl_filt, m_scl_f);
    checkOutput("SCL_rise", scl_rise, m_rise);
    checkOutput("SCL_fall", scl_fall, m_fall);
    checkOutput("start_det", start_det, m_start);
    checkOutput("rstart_det", rstart_det, m_rstart);
    checkOutput("stop_det", stop_det, m_stop);
    checkOutput("bus_error", bus_error, m_err);
    checkOutput("bus_timeout", bus_timeout, m_tmo);
    checkOutput("bus_busy", bus_busy, m_busy);
    n_rise += int'(scl_rise); n_fall += int'(scl_fall);
    n_start += int'(start_det); n_rstart += int'(rstart_det);
    n_stop += int'(stop_det); n_err += int'(bus_error); n_tmo += int'(bus_timeout);
    if (!sda_filt) sda_went_low = 1'b1;
  endtask

  task automatic hold(input logic sda, input logic scl, input int n);
    for (int i = 0; i < n; i++) applyStimulus(sda, scl);
  endtask

  task automatic doReset();
    n_rst   = 1'b0;
    sda_pin = 1'b1;
    scl_pin = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_busy", bus_busy, 1'b0);
    checkOutput("rst_sda_filt", sda_filt, 1'b1);
    checkOutput("rst_scl_filt", scl_filt, 1'b1);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    logic cur_sda, cur_scl;
    int   sel, len;
    n_rst = 1'b1; sda_pin = 1'b1; scl_pin = 1'b1;
    @(negedge clk);
    doReset();

    clearTally();
    hold(1, 1, 20);
    checkOutput("idle_pulses", n_rise + n_fall + n_start + n_stop + n_err + n_tmo, 0);
    checkOutput("idle_busy", bus_busy, 1'b0);

    // START latency, then STOP latency
    clearTally();
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(0, 1);
      if (start_det && first_hit < 0) begin
        first_hit = i;
        checkOutput("busy_with_start", bus_busy, 1'b1);
      end
    end
    checkOutput("start_latency", first_hit, 7);
    clearTally();
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1, 1);
      if (stop_det && first_hit < 0) first_hit = i;
    end
    checkOutput("stop_latency", first_hit, 7);
    checkOutput("busy_after_stop", bus_busy, 1'b0);

    // Short glitch is swallowed, a FD-cycle pulse is not
    clearTally();
    hold(0, 1, 3);
    hold(1, 1, 15);
    checkOutput("glitch3_sda_low", sda_went_low, 1'b0);
    checkOutput("glitch3_start", n_start, 0);
    clearTally();
    hold(0, 1, 4);
    hold(1, 1, 15);
    checkOutput("pulse4_start", n_start, 1);
    checkOutput("pulse4_stop", n_stop, 1);

    // Byte of SCL clocks, then a repeated START
    hold(0, 1, 12);
    clearTally();
    for (int b = 0; b < 8; b++) begin
      hold(0, 0, 50);
      hold(0, 1, 50);
    end
    checkOutput("scl_rises", n_rise, 8);
    checkOutput("scl_falls", n_fall, 8);
    clearTally();
    hold(0, 0, 20);
    hold(1, 0, 20);
    hold(1, 1, 20);
    hold(0, 1, 20);
    checkOutput("rstart_count", n_rstart, 1);
    checkOutput("rstart_no_start", n_start, 0);
    checkOutput("rstart_busy", bus_busy, 1'b1);
    hold(1, 1, 15);

    // Both lines change on the same clk edge
    clearTally();
    hold(0, 0, 15);
    checkOutput("err_count", n_err, 1);
    checkOutput("err_no_start", n_start + n_stop, 0);
    hold(0, 1, 15);
    hold(1, 1, 15);

    // SCL stuck low during a transfer
    hold(0, 1, 12);
    clearTally();
    fall_cyc = -1;
    for (int i = 1; i <= 150; i++) begin
      applyStimulus(0, 0);
      if (scl_fall && fall_cyc < 0) fall_cyc = i;
      if (bus_timeout && first_hit < 0) first_hit = i;
    end
    checkOutput("timeout_count", n_tmo, 1);
    checkOutput("timeout_window", (first_hit - fall_cyc >= 95) && (first_hit - fall_cyc <= 105), 1);
    checkOutput("timeout_idle", bus_busy, 1'b0);
    hold(0, 1, 12);
    hold(1, 1, 12);

    // Reset in the middle of a transfer
    hold(0, 1, 12);
    hold(0, 0, 20);
    checkOutput("mid_busy", bus_busy, 1'b1);
    doReset();
    clearTally();
    hold(1, 1, 20);
    checkOutput("post_rst_pulses", n_rise + n_fall + n_start + n_stop + n_err + n_tmo, 0);

    // Random pad activity with mixed run lengths
    cur_sda = 1'b1;
    cur_scl = 1'b1;
    for (int s = 0; s < 400; s++) begin
      sel = $urandom_range(0, 3);
      len = $urandom_range(1, 2 * FD + 4);
      if (sel == 0 || sel == 2) cur_sda = ~cur_sda;
      if (sel == 1 || sel == 2) cur_scl = ~cur_scl;
      hold(cur_sda, cur_scl, len);
    end
    hold(1, 1, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
